// File: rtl/fc_mac_sequencer_if.sv
// Bus bundle between the FC-layer MAC sequencer and its environment:
// kick/status, feature and weight memory read ports, output memory write port.
interface fc_mac_sequencer_if #(
  parameter int BITWIDTH = 32,
  parameter int N_IN     = 10,
  parameter int N_OUT    = 10
);
  localparam int FA_W = $clog2(N_IN);
  localparam int WA_W = $clog2(N_IN * N_OUT);
  localparam int OA_W = $clog2(N_OUT);

  logic                start;
  logic                busy;
  logic                done;
  logic [FA_W-1:0]     feat_addr;
  logic [BITWIDTH-1:0] feat_rdata;
  logic [WA_W-1:0]     wgt_addr;
  logic [BITWIDTH-1:0] wgt_rdata;
  logic                out_we;
  logic [OA_W-1:0]     out_addr;
  logic [BITWIDTH-1:0] out_wdata;

  // Sequencer side
  modport master (
    input  start, feat_rdata, wgt_rdata,
    output busy, done, feat_addr, wgt_addr, out_we, out_addr, out_wdata
  );

  // Top-level sequencer and memories side
  modport slave (
    output start, feat_rdata, wgt_rdata,
    input  busy, done, feat_addr, wgt_addr, out_we, out_addr, out_wdata
  );
endinterface

// File: rtl/fc_mac_sequencer.sv
// Time-multiplexed 10x10 fully-connected layer: one signed MAC walks the
// connect matrix row by row, reading features/weights from synchronous-read
// memories and writing each Q16-scaled row sum to the output memory.
module fc_mac_sequencer #(
  parameter int BITWIDTH = 32,
  parameter int N_IN     = 10,
  parameter int N_OUT    = 10,
  parameter int SHIFT    = 16
) (
  input logic clk,
  input logic rst,
  fc_mac_sequencer_if.master bus
);
  localparam int FA_W = $clog2(N_IN);
  localparam int WA_W = $clog2(N_IN * N_OUT);
  localparam int OA_W = $clog2(N_OUT);
  localparam int AW   = 2 * BITWIDTH;

  localparam logic [FA_W-1:0] COL_LAST = FA_W'(N_IN - 1);
  localparam logic [OA_W-1:0] ROW_LAST = OA_W'(N_OUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_WRITE,
    S_DONE
  } state_t;

  state_t                state;
  logic [FA_W-1:0]       col;
  logic [OA_W-1:0]       row;
  logic signed [AW-1:0]  acc;
  logic signed [AW-1:0]  prod;
  logic signed [AW-1:0]  sum;

  // Full-width signed product of the words returned for last cycle's address
  always_comb begin
    prod = '0;
    sum  = '0;
    prod = $signed(bus.feat_rdata) * $signed(bus.wgt_rdata);
    sum  = acc + prod;
  end

  // Sequencer FSM; every output is registered so it lines up with the state
  // it belongs to (addresses issued in ISSUE, data returns one cycle later,
  // hence the extra DRAIN cycle for the last product of each row).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      col           <= '0;
      row           <= '0;
      acc           <= '0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.feat_addr <= '0;
      bus.wgt_addr  <= '0;
      bus.out_we    <= 1'b0;
      bus.out_addr  <= '0;
      bus.out_wdata <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            state         <= S_ISSUE;
            col           <= '0;
            row           <= '0;
            bus.busy      <= 1'b1;
            bus.feat_addr <= '0;
            bus.wgt_addr  <= '0;
          end
        end

        S_ISSUE: begin
          // First ISSUE cycle of a row: nothing valid on rdata yet, clear sum
          if (col == '0) acc <= '0;
          else           acc <= sum;
          if (col == COL_LAST) begin
            state <= S_DRAIN;
          end else begin
            col           <= col + 1'b1;
            bus.feat_addr <= col + 1'b1;
            bus.wgt_addr  <= bus.wgt_addr + 1'b1;
          end
        end

        S_DRAIN: begin
          acc           <= sum;
          state         <= S_WRITE;
          bus.out_we    <= 1'b1;
          bus.out_addr  <= row;
          bus.out_wdata <= sum[SHIFT +: BITWIDTH];
        end

        S_WRITE: begin
          bus.out_we <= 1'b0;
          if (row != ROW_LAST) begin
            state         <= S_ISSUE;
            row           <= row + 1'b1;
            col           <= '0;
            bus.feat_addr <= '0;
            // Row-major layout: next row starts right after this row's last
            bus.wgt_addr  <= bus.wgt_addr + 1'b1;
          end else begin
            state         <= S_DONE;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b1;
            bus.feat_addr <= '0;
            bus.wgt_addr  <= '0;
          end
        end

        S_DONE: begin
          bus.done <= 1'b0;
          state    <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fc_mac_sequencer.sv
// Randomised scoreboard bench for fc_mac_sequencer: expected row results are
// computed from the memory contents with plain 64-bit arithmetic and queued
// when a pass is kicked; a monitor pops and compares on every output write.
module tb_fc_mac_sequencer;
  localparam int W  = 32;
  localparam int NI = 10;
  localparam int NO = 10;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fc_mac_sequencer_if #(.BITWIDTH(W), .N_IN(NI), .N_OUT(NO)) bus ();

  fc_mac_sequencer #(.BITWIDTH(W), .N_IN(NI), .N_OUT(NO), .SHIFT(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  logic [W-1:0] fmem [0:15];
  logic [W-1:0] wmem [0:127];

  // Synchronous-read memories
  always @(posedge clk) begin
    bus.feat_rdata <= fmem[bus.feat_addr];
    bus.wgt_rdata  <= wmem[bus.wgt_addr];
  end

  int vectors     = 0;
  int miscompares = 0;
  int done_pulses = 0;
  logic [35:0] sbq [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference: out[j] = floor(sum_i f[i]*w[j][i] / 2^16), kept to 32 bits
  task automatic push_expected();
    for (int j = 0; j < NO; j++) begin
      longint s;
      logic [63:0] u;
      s = 0;
      for (int i = 0; i < NI; i++)
        s += longint'($signed(fmem[i])) * longint'($signed(wmem[j*NI+i]));
      u = s >>> 16;
      sbq.push_back({4'(j), u[31:0]});
    end
  endtask

  // Monitor: every write must match the head of the scoreboard
  always @(negedge clk) begin
    if (bus.done === 1'b1) done_pulses++;
    if (bus.out_we === 1'b1) begin
      if (sbq.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_write at %0t: addr %0h data %0h, none expected",
                 $time, bus.out_addr, bus.out_wdata);
      end else begin
        logic [35:0] e;
        e = sbq.pop_front();
        check("out_addr", 64'(bus.out_addr), 64'(e[35:32]));
        check("out_wdata", 64'(bus.out_wdata), 64'(e[31:0]));
      end
    end
  end

  task automatic fill_const(input logic [W-1:0] f, input logic [W-1:0] w);
    for (int i = 0; i < 16; i++) fmem[i] = f;
    for (int i = 0; i < 128; i++) wmem[i] = w;
  endtask

  function automatic logic [W-1:0] rand_word(input int mode);
    logic [W-1:0] v;
    case (mode)
      0:       v = $urandom;
      1:       v = W'(int'($urandom_range(0, 2097151)) - 1048576);
      default: v = W'((int'($urandom_range(0, 15)) - 8) * 65536);
    endcase
    return v;
  endfunction

  task automatic fill_random();
    int mode;
    mode = int'($urandom_range(0, 2));
    for (int i = 0; i < NI; i++) fmem[i] = rand_word(mode);
    for (int i = 0; i < NI*NO; i++) wmem[i] = rand_word(mode);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (bus.done !== 1'b1 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("done_seen", 64'(bus.done), 64'(1));
    check("busy_at_done", 64'(bus.busy), 64'(0));
    @(posedge clk);
    #1;
    check("done_single", 64'(bus.done), 64'(0));
    check("sb_drained", 64'(sbq.size()), 64'(0));
  endtask

  task automatic run_pass();
    push_expected();
    pulse_start();
    wait_done();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},      64'(bus.busy),      64'(0));
    check({tag, "_done"},      64'(bus.done),      64'(0));
    check({tag, "_out_we"},    64'(bus.out_we),    64'(0));
    check({tag, "_feat_addr"}, 64'(bus.feat_addr), 64'(0));
    check({tag, "_wgt_addr"},  64'(bus.wgt_addr),  64'(0));
    check({tag, "_out_addr"},  64'(bus.out_addr),  64'(0));
    check({tag, "_out_wdata"}, 64'(bus.out_wdata), 64'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 1'b0;
    fill_const('0, '0);
    rst = 1'b1;
    #1;
    check_all_zero("reset");
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    // 2.0 x 1.0 with cycle-accurate timing, ignored and re-triggering starts
    fill_const(32'h0002_0000, 32'h0001_0000);
    push_expected();
    @(negedge clk) bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    for (int c = 1; c <= 123; c++) begin
      logic eb, ed, ew;
      int ef, ewa;
      if (c <= 120) begin
        int k, j, kk;
        k = (c - 1) % 12;
        j = (c - 1) / 12;
        kk = (k < 10) ? k : 9;
        eb = 1'b1; ed = 1'b0; ew = (k == 11); ef = kk; ewa = j*NI + kk;
      end else begin
        eb = (c == 123); ed = (c == 121); ew = 1'b0; ef = 0; ewa = 0;
      end
      check($sformatf("busy_c%0d", c),      64'(bus.busy),      64'(eb));
      check($sformatf("done_c%0d", c),      64'(bus.done),      64'(ed));
      check($sformatf("out_we_c%0d", c),    64'(bus.out_we),    64'(ew));
      check($sformatf("feat_addr_c%0d", c), 64'(bus.feat_addr), 64'(ef));
      check($sformatf("wgt_addr_c%0d", c),  64'(bus.wgt_addr),  64'(ewa));
      bus.start = (c == 5 || c == 121 || c == 122);
      if (c == 122) push_expected();
      @(posedge clk);
      #1;
    end
    bus.start = 1'b0;
    wait_done();

    // -1.0 features, weight row j = (j+1)
    for (int i = 0; i < NI; i++) fmem[i] = 32'hFFFF_0000;
    for (int j = 0; j < NO; j++)
      for (int i = 0; i < NI; i++) wmem[j*NI+i] = W'((j + 1) * 65536);
    run_pass();

    // Floor rounding of tiny sums
    fill_const(32'hFFFF_FFFF, 32'h0000_0001);
    run_pass();
    fill_const(32'h0000_0001, 32'h0000_0001);
    run_pass();

    // Randomised passes
    for (int p = 0; p < 6; p++) begin
      fill_random();
      run_pass();
    end

    // Asynchronous abort in the middle of row 4
    begin
      int dp;
      fill_random();
      push_expected();
      pulse_start();
      repeat (54) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check_all_zero("abort");
      sbq.delete();
      dp = done_pulses;
      repeat (3) @(posedge clk);
      @(negedge clk) rst = 1'b0;
      repeat (140) @(posedge clk);
      #1;
      check("abort_no_done", 64'(done_pulses), 64'(dp));
      check("abort_idle_busy", 64'(bus.busy), 64'(0));
    end

    // Full pass after the abort
    fill_random();
    run_pass();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/fc_mac_sequencer.md
Name: fc_mac_sequencer

Overview:
Time-multiplexed controller for the 10x10 fully-connected layer. It computes the layer with one signed multiply-accumulate unit instead of 100 parallel multipliers. It fetches features and weights from synchronous-read memories, accumulates each output row, and writes each Q16-scaled result to the output vector memory. It sits between the final feature-map buffer and the classifier output buffer, and is kicked by the network top-level sequencer.

Parameters:
BITWIDTH, 32, signed fixed-point word width (Q16 fraction)
N_IN, 10, feature-vector length (columns of connect matrix)
N_OUT, 10, output-vector length (rows of connect matrix)
SHIFT, 16, fractional bits removed from each accumulated sum

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset
start  in  1  pulse; begin a layer pass
busy  out  1  high while a pass is in progress
done  out  1  one-cycle pulse after the last output is written
feat_addr  out  clog2(N_IN)  feature memory read address
feat_rdata  in  BITWIDTH  signed feature word, valid one cycle after address
wgt_addr  out  clog2(N_IN*N_OUT)  weight memory read address, row-major: j*N_IN+i
wgt_rdata  in  BITWIDTH  signed weight word, valid one cycle after address
out_we  out  1  output memory write enable
out_addr  out  clog2(N_OUT)  output index j
out_wdata  out  BITWIDTH  signed scaled result

Behaviour:
- Interface: one clock `clk`; `rst` is asynchronous and active-high.
- Reset: all outputs 0; state IDLE; row/column counters and accumulator cleared. Reset mid-pass aborts immediately; no further writes occur and done does not pulse.
- States:
  - IDLE: wait for start.
  - ISSUE: drive column i = 0..N_IN-1, one per cycle.
  - DRAIN: accumulate the last product.
  - WRITE: write the row result.
  - DONE: pulse done.
- Transitions:
  - IDLE -> ISSUE on start, row j=0.
  - ISSUE -> DRAIN after i=N_IN-1.
  - DRAIN -> WRITE.
  - WRITE -> ISSUE with j+1 if j<N_OUT-1, else -> DONE.
  - DONE -> IDLE.
- Timing: cycle 0 is the cycle start=1 is sampled in IDLE.
  - Row j begins at cycle r = 1 + j*(N_IN+2).
  - ISSUE cycles r..r+N_IN-1 drive feat_addr=i and wgt_addr=j*N_IN+i.
  - Accumulator is cleared at r and adds feat_rdata*wgt_rdata on cycles r+1..r+N_IN (last add in DRAIN).
  - WRITE at r+N_IN+1: out_we=1, out_addr=j.
- Defaults:
  - Last write at cycle N_OUT*(N_IN+2) (120 for defaults).
  - done=1 at the following cycle (121); IDLE from 122.
  - busy=1 for cycles 1..120 inclusive; 0 in IDLE and DONE.
- start while busy, or in DONE, is ignored. A start held high re-triggers only once IDLE is reached.
- Arithmetic:
  - Product is full signed 2*BITWIDTH.
  - Accumulator is 2*BITWIDTH signed and wraps modulo 2^(2*BITWIDTH); no saturation.
  - out_wdata = accumulator bits [SHIFT+BITWIDTH-1:SHIFT]. This is an arithmetic floor divide by 2^SHIFT, truncated to BITWIDTH with no saturation.
- Hold values:
  - out_we is 0 outside WRITE.
  - out_wdata and out_addr hold their last written values.
  - feat_addr and wgt_addr are 0 in IDLE and DONE and hold the last value in DRAIN and WRITE.
- Memories must not be written by others while busy; content changes mid-pass are undefined.

Test Plan:
- Features all 0x00020000 (2.0), weights all 0x00010000 (1.0) -> ten writes, out_wdata=0x00140000 for out_addr 0..9.
- Features all 0xFFFF0000 (-1.0), weight row j all (j+1)*0x10000 -> out[j] = -10*(j+1)*0x10000, e.g. out[0]=0xFFF60000, out[9]=0xFF9C0000.
- Floor rounding: features raw 0xFFFFFFFF (-1 LSB), weights raw 1 -> sum -10 -> every out_wdata=0xFFFFFFFF. With features raw +1 -> every out_wdata=0.
- Timing: start pulse at cycle 0 -> busy rises at cycle 1; addresses 0..9 on cycles 1..10; first out_we at cycle 12; last out_we at cycle 120 with out_addr=9; done single pulse at 121; busy low at 121.
- start reasserted at cycles 5 and 121 -> ignored, exactly 10 writes. start at cycle 122 -> second pass begins, busy at 123.
- rst asserted asynchronously mid-row 4 (cycle 55) -> all outputs 0 immediately, no further writes, no done. A new start after reset produces a full correct pass.
